// File: rtl/sr_pkg.sv
// Shared definitions for the SR command conditioner: FSM state encoding and
// the values of the simultaneous-request priority selector.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LOCKOUT = 2'd2
    } sr_state_e;

    localparam bit PRIORITY_RESET_WINS = 1'b1;
    localparam bit PRIORITY_SET_WINS   = 1'b0;

endpackage

// File: rtl/sr_debounce.sv
// One request channel: two-flop synchroniser, stability debouncer and a
// registered rising-edge detector on the debounced level.
module sr_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Conditions raw set/reset requests into clean, mutually exclusive one-cycle
// S/R pulses with a post-pulse lockout and single-deep per-channel pending.
module sr_cmd_conditioner import sr_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 2,
    parameter bit PRIORITY_RESET  = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      set_raw,
    input  logic      reset_raw,
    output logic      s_out,
    output logic      r_out,
    output logic      conflict,
    output logic      busy,
    output sr_state_e dbg_state
);

    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

    logic      w_set_rise;
    logic      w_reset_rise;

    sr_state_e r_state;
    sr_state_e w_state_nxt;
    logic [LW-1:0] r_lock_cnt;
    logic [LW-1:0] w_lock_cnt_nxt;
    logic      r_pend_set;
    logic      r_pend_reset;
    logic      w_pend_set_nxt;
    logic      w_pend_reset_nxt;
    logic      w_s_nxt;
    logic      w_r_nxt;
    logic      w_conflict_nxt;
    logic      w_want_set;
    logic      w_want_reset;
    logic      w_can_issue;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (set_raw),
        .o_rise (w_set_rise)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (reset_raw),
        .o_rise (w_reset_rise)
    );

    assign w_want_set   = w_set_rise   | r_pend_set;
    assign w_want_reset = w_reset_rise | r_pend_reset;

    // The last lockout cycle arbitrates like IDLE so a pending request is
    // served exactly LOCKOUT_CYCLES+1 cycles after the previous pulse.
    assign w_can_issue = (r_state == IDLE) ||
                         ((r_state == LOCKOUT) && (r_lock_cnt == LOCK_ONE)) ||
                         ((r_state == ISSUE) && (LOCKOUT_CYCLES == 0));

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_cnt_nxt   = r_lock_cnt;
        w_pend_set_nxt   = r_pend_set   | w_set_rise;
        w_pend_reset_nxt = r_pend_reset | w_reset_rise;
        w_s_nxt          = 1'b0;
        w_r_nxt          = 1'b0;
        w_conflict_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
            end
            ISSUE: begin
                if (LOCKOUT_CYCLES > 0) begin
                    w_state_nxt    = LOCKOUT;
                    w_lock_cnt_nxt = LOCK_LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKOUT: begin
                w_lock_cnt_nxt = r_lock_cnt - 1'b1;
                if (r_lock_cnt == LOCK_ONE) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_can_issue && (w_want_set || w_want_reset)) begin
            w_state_nxt      = ISSUE;
            w_pend_set_nxt   = 1'b0;
            w_pend_reset_nxt = 1'b0;
            if (w_want_set && w_want_reset) begin
                w_conflict_nxt = 1'b1;
                if (PRIORITY_RESET == PRIORITY_RESET_WINS) begin
                    w_r_nxt = 1'b1;
                end else begin
                    w_s_nxt = 1'b1;
                end
            end else if (w_want_set) begin
                w_s_nxt = 1'b1;
            end else begin
                w_r_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_lock_cnt   <= '0;
            r_pend_set   <= 1'b0;
            r_pend_reset <= 1'b0;
            s_out        <= 1'b0;
            r_out        <= 1'b0;
            conflict     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_pend_set   <= w_pend_set_nxt;
            r_pend_reset <= w_pend_reset_nxt;
            s_out        <= w_s_nxt;
            r_out        <= w_r_nxt;
            conflict     <= w_conflict_nxt;
            busy         <= (w_state_nxt != IDLE);
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner: latency, bounce rejection, priority,
// pending service, reset abort and a randomised invariant soak.
module tb_sr_cmd_conditioner;
    import sr_pkg::*;

    localparam int LOCK = 2;

    logic clk;
    logic rst;
    logic set_raw;
    logic reset_raw;
    logic s_r, r_r, c_r, b_r;
    logic s_s, r_s, c_s, b_s;
    sr_state_e st_r;
    sr_state_e st_s;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int last_r = -1000;
    int last_s = -1000;
    int n_s_r = 0, n_r_r = 0, n_c_r = 0;
    int n_s_s = 0, n_r_s = 0, n_c_s = 0;
    int n_both = 0, n_gap = 0, n_busy_err = 0;

    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(LOCK), .PRIORITY_RESET(1'b1)) dut_r (
        .clk(clk), .rst(rst), .set_raw(set_raw), .reset_raw(reset_raw),
        .s_out(s_r), .r_out(r_r), .conflict(c_r), .busy(b_r), .dbg_state(st_r)
    );

    sr_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(LOCK), .PRIORITY_RESET(1'b0)) dut_s (
        .clk(clk), .rst(rst), .set_raw(set_raw), .reset_raw(reset_raw),
        .s_out(s_s), .r_out(r_s), .conflict(c_s), .busy(b_s), .dbg_state(st_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            last_r <= -1000;
            last_s <= -1000;
        end else begin
            if (s_r) n_s_r <= n_s_r + 1;
            if (r_r) n_r_r <= n_r_r + 1;
            if (c_r) n_c_r <= n_c_r + 1;
            if (s_s) n_s_s <= n_s_s + 1;
            if (r_s) n_r_s <= n_r_s + 1;
            if (c_s) n_c_s <= n_c_s + 1;
            if ((s_r && r_r) || (s_s && r_s)) n_both <= n_both + 1;
            if (s_r || r_r) begin
                if (cyc - last_r < LOCK + 1) n_gap <= n_gap + 1;
                last_r <= cyc;
            end
            if (s_s || r_s) begin
                if (cyc - last_s < LOCK + 1) n_gap <= n_gap + 1;
                last_s <= cyc;
            end
            if ((b_r != (st_r != IDLE)) || (b_s != (st_s != IDLE)))
                n_busy_err <= n_busy_err + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int base_s, base_r, base_c, base_s2, base_r2, base_c2;
    int early, busy_run, base_both, base_gap, base_pulses;

    initial begin
        rst = 1'b1;
        set_raw = 1'b0;
        reset_raw = 1'b0;
        idle(3);
        chk("rst_s", s_r, 0);
        chk("rst_r", r_r, 0);
        chk("rst_conf", c_r, 0);
        chk("rst_busy", b_r, 0);
        chk("rst_state", st_r, IDLE);
        rst = 1'b0;
        idle(2);

        // Latency: clean set rise, pulse on edge k+7 then 2 lockout cycles.
        base_s = n_s_r; base_r = n_r_r; base_c = n_c_r;
        early = 0; busy_run = 0;
        set_raw = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            if (j < 7 && (s_r || b_r)) early++;
            if (j == 7) begin
                chk("t1_s", s_r, 1);
                chk("t1_r", r_r, 0);
                chk("t1_conf", c_r, 0);
                chk("t1_busy", b_r, 1);
            end
            if ((j == 8 || j == 9) && b_r && !s_r) busy_run++;
            if (j == 10) chk("t1_busy_end", b_r, 0);
        end
        chk("t1_early", early, 0);
        chk("t1_busy_lock", busy_run, 2);
        chk("t1_npulse", n_s_r - base_s, 1);
        chk("t1_nr", n_r_r - base_r, 0);
        chk("t1_nconf", n_c_r - base_c, 0);
        set_raw = 1'b0;
        idle(15);
        chk("t1_fall_quiet", n_s_r - base_s, 1);

        // Bounce: 1,0,1,0 one cycle each, then a stable hold.
        base_s = n_s_r;
        early = 0;
        set_raw = 1'b1; step();
        set_raw = 1'b0; step();
        set_raw = 1'b1; step();
        set_raw = 1'b0; step();
        set_raw = 1'b1;
        for (int j = 0; j < 16; j++) begin
            step();
            if (j < 7 && s_r) early++;
            if (j == 7) chk("t2_s", s_r, 1);
        end
        chk("t2_early", early, 0);
        chk("t2_npulse", n_s_r - base_s, 1);
        set_raw = 1'b0;
        idle(15);

        // Simultaneous rise: reset wins on dut_r, set wins on dut_s.
        base_s = n_s_r; base_r = n_r_r; base_c = n_c_r;
        base_s2 = n_s_s; base_r2 = n_r_s; base_c2 = n_c_s;
        set_raw = 1'b1;
        reset_raw = 1'b1;
        for (int j = 0; j < 16; j++) begin
            step();
            if (j == 7) begin
                chk("t3r_r", r_r, 1);
                chk("t3r_conf", c_r, 1);
                chk("t3r_s", s_r, 0);
                chk("t3s_s", s_s, 1);
                chk("t3s_conf", c_s, 1);
                chk("t3s_r", r_s, 0);
            end
        end
        chk("t3r_ns", n_s_r - base_s, 0);
        chk("t3r_nr", n_r_r - base_r, 1);
        chk("t3r_nc", n_c_r - base_c, 1);
        chk("t3s_nr", n_r_s - base_r2, 0);
        chk("t3s_ns", n_s_s - base_s2, 1);
        chk("t3s_nc", n_c_s - base_c2, 1);
        set_raw = 1'b0;
        reset_raw = 1'b0;
        idle(15);

        // Pending: reset request lands one cycle after the set pulse.
        base_s = n_s_r; base_r = n_r_r; base_c = n_c_r;
        early = 0;
        set_raw = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            if (j == 0) reset_raw = 1'b1;
            if (j == 7) chk("t4_s", s_r, 1);
            if ((j == 8 || j == 9) && r_r) early++;
            if (j == 10) begin
                chk("t4_r", r_r, 1);
                chk("t4_s_off", s_r, 0);
                chk("t4_conf", c_r, 0);
                chk("t4_s_dut_s", r_s, 1);
            end
        end
        chk("t4_early", early, 0);
        chk("t4_ns", n_s_r - base_s, 1);
        chk("t4_nr", n_r_r - base_r, 1);
        chk("t4_nc", n_c_r - base_c, 0);
        set_raw = 1'b0;
        reset_raw = 1'b0;
        idle(15);

        // Reset during lockout with a pending set: nothing may be replayed.
        reset_raw = 1'b1;
        for (int j = 0; j < 9; j++) begin
            step();
            if (j == 0) set_raw = 1'b1;
            if (j == 7) chk("t5_r", r_r, 1);
            if (j == 8) begin
                chk("t5_lock_busy", b_r, 1);
                chk("t5_lock_state", st_r, LOCKOUT);
            end
        end
        rst = 1'b1;
        set_raw = 1'b0;
        reset_raw = 1'b0;
        step();
        chk("t5_s", s_r, 0);
        chk("t5_r0", r_r, 0);
        chk("t5_conf", c_r, 0);
        chk("t5_busy", b_r, 0);
        chk("t5_state", st_r, IDLE);
        rst = 1'b0;
        base_s = n_s_r; base_r = n_r_r;
        idle(30);
        chk("t5_no_replay_s", n_s_r - base_s, 0);
        chk("t5_no_replay_r", n_r_r - base_r, 0);

        // Random bouncing on both inputs.
        base_both = n_both;
        base_gap = n_gap;
        base_pulses = n_s_r + n_r_r;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 5) == 0) set_raw = ~set_raw;
            if ($urandom_range(0, 5) == 0) reset_raw = ~reset_raw;
            step();
        end
        set_raw = 1'b0;
        reset_raw = 1'b0;
        idle(20);
        chk("t6_exclusive", n_both - base_both, 0);
        chk("t6_gap", n_gap - base_gap, 0);
        chk("t6_activity", ((n_s_r + n_r_r - base_pulses) > 0) ? 1 : 0, 1);
        chk("busy_state", n_busy_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
